bin_to_ascii_fmt: RTL and testbench
===================================

Name: bin_to_ascii_fmt

Overview:
Parametrised successor to the decimal-to-ASCII converter feeding the ZynqOLED text buffer. Converts a DATA_W-bit binary word into a fixed, right-justified ASCII field of FIELD_CHARS characters. Selectable per request: unsigned or signed decimal, or hex; space or zero padding. Uses an iterative shift engine (double-dabble) with fixed latency, and presents a held output plus a one-cycle complete pulse to the OLED string mux.

Parameters:
DATA_W, 32, input word width; multiple of 4, >= 8
DEC_DIGITS, 10, BCD digits held by the engine; 10^DEC_DIGITS > 2^DATA_W required
FIELD_CHARS, 16, output field width in characters; >= DEC_DIGITS+1 and >= DATA_W/4

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
decimal  in  DATA_W  value to convert; sampled on accept
load_data  in  1  request; accepted on a clock edge only while idle
mode_signed  in  1  1 = treat decimal as two's complement (decimal mode only)
mode_hex  in  1  1 = hex output, 0 = decimal
pad_zero  in  1  1 = pad with '0', 0 = pad with ' '
busy  out  1  conversion in progress
complete  out  1  one-cycle pulse: ascii updated this cycle
ascii  out  FIELD_CHARS*8  char 0 (rightmost/least significant) in bits [7:0]; leftmost char in MSBs

Behaviour:
- Reset (async, reset=0): state IDLE, busy=0, complete=0, ascii = every byte 0x20, engine registers cleared. Takes effect immediately, including mid-conversion. The partial result is discarded and ascii returns to spaces.
- FSM states: IDLE, SHIFT, FORMAT.
- IDLE: on edge T0 with load_data=1, capture the operation.
  - Captured: mag, neg, mode_hex, pad_zero.
  - neg = mode_signed & ~mode_hex & decimal[DATA_W-1].
  - mag = neg ? -decimal : decimal, taken as unsigned DATA_W bits. The most negative value yields 2^(DATA_W-1) and converts correctly.
  - Set busy=1, clear BCD/nibble accumulator and shift counter, go to SHIFT.
- SHIFT: exactly DATA_W edges (T1..T_DATA_W). Each edge shifts one mag MSB into the accumulator.
  - Decimal mode: before the shift, add 3 to every BCD digit >= 5.
  - Hex mode: no correction, so the accumulator holds raw nibbles.
  - After edge T_DATA_W, go to FORMAT.
- FORMAT (edge T_DATA_W+1): ascii is written in one cycle, complete=1 for exactly that cycle, busy=0, state goes to IDLE.
- Latency: complete is high in the cycle after edge DATA_W+1 counted from the accept edge (34 edges for DATA_W=32). Minimum request spacing is DATA_W+2 cycles.
- load_data while busy or during the FORMAT-completion cycle is ignored, with no queueing. A new accept is possible on the first edge after complete rises.
- Digit characters: '0'-'9' = 0x30-0x39; hex 'A'-'F' = 0x41-0x46 (uppercase).
- Leading-zero suppression: digits above the most significant nonzero digit become pad. A value of 0 shows a single '0' at char 0.
- Sign handling:
  - Space pad: '-' (0x2D) is placed immediately left of the first significant digit.
  - Zero pad: '-' is placed at the leftmost char (FIELD_CHARS-1) and zeros fill the gap.
  - Hex mode never shows a sign. mode_signed is ignored in hex mode.
- Field positions above the digit/sign span are always pad (' ' or '0').
- ascii holds its value between completes. It changes only at FORMAT and at reset.
- Unused accumulator digits (hex: beyond DATA_W/4; decimal: beyond DEC_DIGITS) are never displayed as significant.

Decomposition:
- Package bin_to_ascii_pkg holds:
  - FSM state enum (IDLE, SHIFT, FORMAT).
  - ASCII constants: SPACE 0x20, ZERO 0x30, MINUS 0x2D, HEX_A 0x41.
  - Function digit_to_ascii(nibble).
  - Localparam for shift counter width, $clog2(DATA_W+1).
- Sub-module bcd_shift_step: combinational add-3-then-shift for the accumulator, with a hex-bypass input, instantiated once.
- The top level owns the FSM, the capture registers and the FORMAT packer.

Test Plan:
- Reset low 10 cycles, release. Then decimal mode, unsigned, space pad, load 12812 -> busy for 33 cycles; complete pulses at edge 34; ascii = 11 spaces + "12812"; pulse is exactly 1 cycle.
- 32'hFFFF_FFFF unsigned -> "      4294967295". Same input signed -> "              -1". 32'h8000_0000 signed -> "     -2147483648".
- Hex mode: 32'h0000_BEEF -> 12 spaces + "BEEF". 32'h0 -> 15 spaces + "0". Hex with mode_signed=1 and 32'hFFFF_FFFF -> 8 spaces + "FFFFFFFF" (no sign).
- pad_zero=1, signed, 32'hFFFF_FFFF -> "-000000000000001". Unsigned 128 -> "0000000000000128".
- Hold load_data high throughout a conversion: only one accept occurs and ascii stays stable until complete. A second accept happens on the edge after complete, and back-to-back period = 34 cycles.
- Assert reset at cycle 15 of a conversion -> busy=0, complete=0 and ascii = all spaces immediately (asynchronous). A fresh load of 12 then yields "              12".

Source files
------------

// File: rtl/bin_to_ascii_pkg.sv
// Shared types, character constants and helpers for the binary-to-ASCII field formatter.
package bin_to_ascii_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FORMAT = 2'd2
    } state_t;

    localparam logic [7:0] SPACE = 8'h20;
    localparam logic [7:0] ZERO  = 8'h30;
    localparam logic [7:0] MINUS = 8'h2D;
    localparam logic [7:0] HEX_A = 8'h41;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_CNT_W  = $clog2(DEF_DATA_W + 1);

    // Per-request formatting options captured on accept
    typedef struct packed {
        logic neg;
        logic hex;
        logic pad_zero;
    } fmt_t;

    function automatic logic [7:0] digit_to_ascii(input logic [3:0] nibble);
        if (nibble < 4'd10)
            return ZERO + {4'd0, nibble};
        else
            return HEX_A + {4'd0, nibble - 4'd10};
    endfunction

endpackage

// File: rtl/bcd_shift_step.sv
// One double-dabble step: add 3 to every digit >= 5, then shift in one bit.
// With hex_bypass set the correction is skipped and the digits are raw nibbles.
module bcd_shift_step #(
    parameter int DIGITS = 10
) (
    input  logic [DIGITS*4-1:0] acc,
    input  logic                bit_in,
    input  logic                hex_bypass,
    output logic [DIGITS*4-1:0] acc_next
);

    logic [DIGITS*4-1:0] adj;

    for (genvar g = 0; g < DIGITS; g++) begin : g_dig
        assign adj[g*4 +: 4] = (!hex_bypass && (acc[g*4 +: 4] >= 4'd5))
                             ? acc[g*4 +: 4] + 4'd3
                             : acc[g*4 +: 4];
    end

    assign acc_next = {adj[DIGITS*4-2:0], bit_in};

endmodule

// File: rtl/bin_to_ascii_fmt.sv
// Converts a binary word into a right-justified ASCII field (signed/unsigned
// decimal or hex, space or zero pad) using a fixed-latency shift engine.
module bin_to_ascii_fmt
    import bin_to_ascii_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int DEC_DIGITS  = 10,
    parameter int FIELD_CHARS = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [DATA_W-1:0]        decimal,
    input  logic                     load_data,
    input  logic                     mode_signed,
    input  logic                     mode_hex,
    input  logic                     pad_zero,
    output logic                     busy,
    output logic                     complete,
    output logic [FIELD_CHARS*8-1:0] ascii
);

    localparam int HEX_DIGITS = DATA_W / 4;
    localparam int ACC_DIGITS = (DEC_DIGITS > HEX_DIGITS) ? DEC_DIGITS : HEX_DIGITS;
    localparam int CNT_W      = $clog2(DATA_W + 1);

    state_t                   state;
    fmt_t                     fmt;
    logic [DATA_W-1:0]        mag;
    logic [ACC_DIGITS*4-1:0]  acc;
    logic [ACC_DIGITS*4-1:0]  acc_next;
    logic [CNT_W-1:0]         cnt;
    logic                     neg_in;
    logic [DATA_W-1:0]        mag_in;
    logic [FIELD_CHARS*4-1:0] digs;
    logic [FIELD_CHARS*8-1:0] ascii_next;
    logic [7:0]               pad;
    int                       lim;
    int                       nd;

    // Sign/magnitude split of the incoming request; hex is always unsigned
    assign neg_in = mode_signed & ~mode_hex & decimal[DATA_W-1];
    assign mag_in = neg_in ? (DATA_W'(0) - decimal) : decimal;

    bcd_shift_step #(.DIGITS(ACC_DIGITS)) u_step (
        .acc        (acc),
        .bit_in     (mag[DATA_W-1]),
        .hex_bypass (fmt.hex),
        .acc_next   (acc_next)
    );

    // Accumulator widened to the field so every char position has a digit slot
    assign digs = (FIELD_CHARS*4)'(acc);

    // Field packer: significant digits, sign placement and padding
    always_comb begin
        lim        = fmt.hex ? HEX_DIGITS : DEC_DIGITS;
        pad        = fmt.pad_zero ? ZERO : SPACE;
        nd         = 1;
        ascii_next = '0;
        for (int j = 0; j < FIELD_CHARS; j++) begin
            if (j < lim && digs[j*4 +: 4] != 4'd0)
                nd = j + 1;
        end
        for (int i = 0; i < FIELD_CHARS; i++) begin
            if (i < nd)
                ascii_next[i*8 +: 8] = digit_to_ascii(digs[i*4 +: 4]);
            else if (fmt.neg && fmt.pad_zero && i == FIELD_CHARS - 1)
                ascii_next[i*8 +: 8] = MINUS;
            else if (fmt.neg && !fmt.pad_zero && i == nd)
                ascii_next[i*8 +: 8] = MINUS;
            else
                ascii_next[i*8 +: 8] = pad;
        end
    end

    // Control FSM, capture registers and shift engine state
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            complete <= 1'b0;
            ascii    <= {FIELD_CHARS{SPACE}};
            fmt      <= '0;
            mag      <= '0;
            acc      <= '0;
            cnt      <= '0;
        end else begin
            complete <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_data) begin
                        mag   <= mag_in;
                        fmt   <= '{neg: neg_in, hex: mode_hex, pad_zero: pad_zero};
                        acc   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    acc <= acc_next;
                    mag <= {mag[DATA_W-2:0], 1'b0};
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(DATA_W - 1))
                        state <= FORMAT;
                end
                FORMAT: begin
                    ascii    <= ascii_next;
                    complete <= 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_ascii_fmt.sv
// Self-checking bench: directed vector table, random vectors against a
// string-building reference model, plus hold-load and async-reset sequences.
module tb_bin_to_ascii_fmt;

    localparam int FC = 16;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [31:0]   decimal = '0;
    logic          load_data = 1'b0;
    logic          mode_signed = 1'b0;
    logic          mode_hex = 1'b0;
    logic          pad_zero = 1'b0;
    logic          busy;
    logic          complete;
    logic [FC*8-1:0] ascii;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0]     val;
        logic            sgn;
        logic            hex;
        logic            pz;
        logic [FC*8-1:0] exp;
    } vec_t;

    vec_t tbl[12];

    always #5 clock = ~clock;

    bin_to_ascii_fmt #(.DATA_W(32), .DEC_DIGITS(10), .FIELD_CHARS(FC)) dut (
        .clock       (clock),
        .reset       (reset),
        .decimal     (decimal),
        .load_data   (load_data),
        .mode_signed (mode_signed),
        .mode_hex    (mode_hex),
        .pad_zero    (pad_zero),
        .busy        (busy),
        .complete    (complete),
        .ascii       (ascii)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [FC*8-1:0] act, input logic [FC*8-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference: divide-and-collect digits, then lay the field out right-justified
    function automatic logic [FC*8-1:0] model(input logic [31:0] v, input logic s, input logic h, input logic p);
        byte         c[FC];
        byte         d[$];
        longint      m;
        longint      base;
        bit          neg;
        logic [FC*8-1:0] r;
        neg  = s && !h && v[31];
        m    = neg ? (64'h1_0000_0000 - longint'(v)) : longint'(v);
        base = h ? 16 : 10;
        do begin
            d.push_back(byte'(m % base));
            m = m / base;
        end while (m != 0);
        for (int i = 0; i < FC; i++) begin
            if (i < d.size())
                c[i] = (d[i] < 10) ? byte'(8'h30 + d[i]) : byte'(8'h41 + d[i] - 10);
            else
                c[i] = p ? 8'h30 : 8'h20;
        end
        if (neg) begin
            if (p) c[FC-1] = 8'h2D;
            else   c[d.size()] = 8'h2D;
        end
        for (int i = 0; i < FC; i++) r[i*8 +: 8] = c[i];
        return r;
    endfunction

    task automatic start(input logic [31:0] v, input logic s, input logic h, input logic p);
        @(negedge clock);
        decimal = v; mode_signed = s; mode_hex = h; pad_zero = p; load_data = 1'b1;
        @(posedge clock);
        #1;
        load_data = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!complete && n < 100) begin
            @(posedge clock);
            #1;
            n++;
        end
    endtask

    task automatic convert(input string name, input logic [31:0] v, input logic s,
                           input logic h, input logic p, input logic [FC*8-1:0] exp);
        int n;
        start(v, s, h, p);
        check({name, "_busy"}, FC*8'(busy), FC*8'(1));
        wait_done(n);
        check({name, "_latency"}, FC*8'(n), FC*8'(33));
        check({name, "_ascii"}, ascii, exp);
        @(posedge clock);
        #1;
        check({name, "_pulse"}, FC*8'(complete), FC*8'(0));
    endtask

    initial begin
        int t;
        int bad;
        logic [31:0] v;
        logic s, h, p;

        tbl[0]  = '{32'd12812,      1'b0, 1'b0, 1'b0, "           12812"};
        tbl[1]  = '{32'hFFFF_FFFF,  1'b0, 1'b0, 1'b0, "      4294967295"};
        tbl[2]  = '{32'hFFFF_FFFF,  1'b1, 1'b0, 1'b0, "              -1"};
        tbl[3]  = '{32'h8000_0000,  1'b1, 1'b0, 1'b0, "     -2147483648"};
        tbl[4]  = '{32'h0000_BEEF,  1'b0, 1'b1, 1'b0, "            BEEF"};
        tbl[5]  = '{32'h0,          1'b0, 1'b1, 1'b0, "               0"};
        tbl[6]  = '{32'hFFFF_FFFF,  1'b1, 1'b1, 1'b0, "        FFFFFFFF"};
        tbl[7]  = '{32'hFFFF_FFFF,  1'b1, 1'b0, 1'b1, "-000000000000001"};
        tbl[8]  = '{32'd128,        1'b0, 1'b0, 1'b1, "0000000000000128"};
        tbl[9]  = '{32'h0,          1'b1, 1'b0, 1'b0, "               0"};
        tbl[10] = '{32'h8000_0000,  1'b1, 1'b0, 1'b1, "-000002147483648"};
        tbl[11] = '{32'h0000_BEEF,  1'b0, 1'b1, 1'b1, "000000000000BEEF"};

        // Reset state
        repeat (10) @(posedge clock);
        #1;
        check("rst_busy", FC*8'(busy), FC*8'(0));
        check("rst_complete", FC*8'(complete), FC*8'(0));
        check("rst_ascii", ascii, {FC{8'h20}});
        @(negedge clock);
        reset = 1'b1;

        // Directed table
        for (int i = 0; i < 12; i++)
            convert($sformatf("tbl%0d", i), tbl[i].val, tbl[i].sgn, tbl[i].hex, tbl[i].pz, tbl[i].exp);

        // Random vectors against the reference model
        for (int i = 0; i < 40; i++) begin
            v = $urandom;
            if ($urandom_range(0, 3) == 0) v = $urandom_range(0, 999);
            if ($urandom_range(0, 7) == 0) v = 32'hFFFF_FFFF - $urandom_range(0, 20);
            s = 1'($urandom_range(0, 1));
            h = 1'($urandom_range(0, 1));
            p = 1'($urandom_range(0, 1));
            convert($sformatf("rnd%0d", i), v, s, h, p, model(v, s, h, p));
        end

        // load_data held high: single accept, input resampled only after complete
        @(negedge clock);
        decimal = 32'd111; mode_signed = 1'b0; mode_hex = 1'b0; pad_zero = 1'b0; load_data = 1'b1;
        @(posedge clock);
        #1;
        t = 0;
        while (!complete && t < 100) begin
            @(posedge clock);
            #1;
            t++;
            if (t == 5) decimal = 32'd222;
        end
        check("hold_first_latency", FC*8'(t), FC*8'(33));
        check("hold_first_ascii", ascii, model(32'd111, 1'b0, 1'b0, 1'b0));
        bad = 0;
        @(posedge clock);
        #1;
        t++;
        while (!complete && t < 150) begin
            if (ascii !== model(32'd111, 1'b0, 1'b0, 1'b0)) bad++;
            @(posedge clock);
            #1;
            t++;
        end
        load_data = 1'b0;
        check("hold_stable_cycles_bad", FC*8'(bad), FC*8'(0));
        check("hold_second_edge", FC*8'(t), FC*8'(67));
        check("hold_second_ascii", ascii, model(32'd222, 1'b0, 1'b0, 1'b0));
        repeat (2) @(posedge clock);
        #1;
        check("hold_no_third", FC*8'(busy), FC*8'(0));

        // Asynchronous reset in the middle of a conversion
        start(32'd12812, 1'b0, 1'b0, 1'b0);
        repeat (14) @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        check("arst_busy", FC*8'(busy), FC*8'(0));
        check("arst_complete", FC*8'(complete), FC*8'(0));
        check("arst_ascii", ascii, {FC{8'h20}});
        @(negedge clock);
        reset = 1'b1;
        convert("after_rst", 32'd12, 1'b0, 1'b0, 1'b0, "              12");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
